systolic_sequencer: RTL and testbench
=====================================

# systolic_sequencer

Control FSM for the MATRIX_SIZE×MATRIX_SIZE systolic multiply array. On a start request it clears the PE accumulators, then steps the input fetcher through a skewed feed window so lane i enters the array i cycles after lane 0. It waits for the wavefront to reach the last PE, then drains result rows over a ready/valid handshake. It sits between the host/command side and the data fetcher, PE grid and result writer.

## Interface
- MATRIX_SIZE, 2: array dimension N (N ≥ 2)
- CNT_W, 8: width of the step/row counters; must hold 2N−2 and N−1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  run request; accepted only when start_ready=1
- start_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- abort  in  1  synchronous cancel of an in-flight run
- pe_clear  out  1  clears all PE accumulators; high in CLEAR
- feed_en  out  1  fetcher advance; high in FEED
- feed_step  out  CNT_W  feed cycle index t, 0..2N−2
- lane_valid  out  N  bit i high when lane i carries real data this cycle
- compute_en  out  1  PE accumulate enable; high in FEED and FLUSH
- drain_valid  out  1  result row drain_row is presented
- drain_row  out  CNT_W  index of the row being drained, 0..N−1
- drain_ready  in  1  downstream accepts the row

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. All outputs are decoded from registered state and counters, so no output is combinational from an input.
- IDLE: waits for start. When start=1 the FSM goes to CLEAR and ignores abort in that cycle.
- CLEAR: lasts 1 cycle with pe_clear=1, then goes to FEED with feed_step=0.
- FEED: lasts 2N−1 cycles. feed_step counts 0..2N−2. lane_valid[i] = (t ≥ i) && (t < i+N). The lane i operand index is t−i, which the fetcher computes. After t=2N−2 the FSM goes to FLUSH.
- FLUSH: lasts N cycles so the last PE (N−1,N−1) completes its final MAC. lane_valid=0 and feed_en=0. Then the FSM goes to DRAIN with drain_row=0.
- DRAIN: drain_valid=1. drain_row advances only on drain_valid && drain_ready. The handshake at row N−1 moves the FSM to DONE. While drain_ready=0, drain_row and drain_valid hold.
- DONE: lasts 1 cycle with done=1, then returns to IDLE.
- abort=1 in CLEAR, FEED, FLUSH or DRAIN sends the FSM to IDLE on the next edge. No done pulse is produced, and counters return to 0. abort is ignored in IDLE and DONE.
- start while busy is ignored and not queued. start and done can never coincide because start_ready=0 in DONE.
- Counters saturate within their state and never wrap. feed_step and drain_row are 0 outside FEED and DRAIN respectively.

## Timing
- Reset (asynchronous, reset=0) takes effect immediately, without waiting for clk. The FSM goes to IDLE with start_ready=1 and all other outputs 0, including feed_step and drain_row.
- Reset release is synchronous to the next clk edge. Reset mid-run discards the run and produces no done.
- Let E0 be the edge where start is sampled. pe_clear is high in cycle E0+1, FEED spans E0+2..E0+2N, FLUSH spans the next N cycles, and DRAIN spans the next ≥N cycles.
- Without stalls, done rises 4N cycles after E0 and start_ready returns 1 cycle later. For N=2 this is 9 cycles of busy.
- Each stall cycle (drain_ready=0 during DRAIN) adds exactly 1 cycle to total latency.
- Back-to-back runs: the earliest next start is the first IDLE cycle, so 1 idle cycle separates runs.

## Test plan
- Reset then start pulse, N=2, drain_ready=1 → pe_clear at E0+1. feed_step 0,1,2 with lane_valid 01,11,10. compute_en high 5 cycles. drain_row 0,1. done at E0+8. busy high 9 cycles.
- Same run with drain_ready low for 3 cycles at drain_row=1 → drain_row holds at 1 with drain_valid=1. done is delayed 3 cycles to E0+11.
- abort in FEED at feed_step=1 → next cycle IDLE, start_ready=1, feed_step=0, no done. A subsequent start runs a normal full sequence.
- start held high continuously → only one run per IDLE visit. A new CLEAR follows each DONE→IDLE with a 1-cycle IDLE gap.
- reset asserted mid-DRAIN (not clock-aligned) → all outputs go to reset values immediately. After release, busy=0 until start.
- N=4 → FEED lasts 7 cycles with lane_valid walking 0001…1111…1000, FLUSH lasts 4 cycles, and done arrives 16 cycles after E0.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Control sequencer for an N x N systolic multiply array.
// Runs one job per start: clear the PE accumulators, feed a skewed operand
// window, flush the wavefront to the last PE, then drain result rows over a
// valid/ready handshake and pulse done.
// Drain handshake: a row transfers on a clock edge where drain_valid and
// drain_ready are both high; drain_valid and drain_row stay stable until then.
// Every output is a flop written together with the state register, so no
// output has a combinational path from an input.
module systolic_sequencer #(
    parameter int MATRIX_SIZE = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   start_ready,
    output logic                   busy,
    output logic                   done,
    input  logic                   abort,
    output logic                   pe_clear,
    output logic                   feed_en,
    output logic [CNT_W-1:0]       feed_step,
    output logic [MATRIX_SIZE-1:0] lane_valid,
    output logic                   compute_en,
    output logic                   drain_valid,
    output logic [CNT_W-1:0]       drain_row,
    input  logic                   drain_ready,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Last feed step is 2N-2, last flush cycle and last drain row are N-1.
    localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(2 * MATRIX_SIZE - 2);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;

    // Lane i carries real data for feed steps i .. i+N-1 (skewed window).
    function automatic logic [MATRIX_SIZE-1:0] lanes(input logic [CNT_W-1:0] t);
        logic [MATRIX_SIZE-1:0] lv;
        lv = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            lv[i] = (int'(t) >= i) && (int'(t) < i + MATRIX_SIZE);
        end
        return lv;
    endfunction

    assign state_dbg = state;

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pe_clear    <= 1'b0;
            feed_en     <= 1'b0;
            feed_step   <= '0;
            lane_valid  <= '0;
            compute_en  <= 1'b0;
            drain_valid <= 1'b0;
            drain_row   <= '0;
        end else if (abort && (state == CLEAR || state == FEED ||
                               state == FLUSH || state == DRAIN)) begin
            // Cancel drops straight back to idle with no done pulse.
            state       <= IDLE;
            flush_cnt   <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pe_clear    <= 1'b0;
            feed_en     <= 1'b0;
            feed_step   <= '0;
            lane_valid  <= '0;
            compute_en  <= 1'b0;
            drain_valid <= 1'b0;
            drain_row   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CLEAR;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        pe_clear    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= FEED;
                    pe_clear   <= 1'b0;
                    feed_en    <= 1'b1;
                    feed_step  <= '0;
                    lane_valid <= lanes('0);
                    compute_en <= 1'b1;
                end
                FEED: begin
                    if (feed_step == FEED_LAST) begin
                        state      <= FLUSH;
                        feed_en    <= 1'b0;
                        feed_step  <= '0;
                        lane_valid <= '0;
                        flush_cnt  <= '0;
                    end else begin
                        feed_step  <= feed_step + CNT_ONE;
                        lane_valid <= lanes(feed_step + CNT_ONE);
                    end
                end
                FLUSH: begin
                    // N cycles so the far corner PE finishes its last MAC.
                    if (flush_cnt == ROW_LAST) begin
                        state       <= DRAIN;
                        flush_cnt   <= '0;
                        compute_en  <= 1'b0;
                        drain_valid <= 1'b1;
                        drain_row   <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_ready) begin
                        if (drain_row == ROW_LAST) begin
                            state       <= DONE;
                            drain_valid <= 1'b0;
                            drain_row   <= '0;
                            done        <= 1'b1;
                        end else begin
                            drain_row <= drain_row + CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: an N=2 and an N=4 instance, each checked
// cycle by cycle against a phase-list reference built from the run rules.
module tb_systolic_sequencer;

    localparam int CW = 8;
    localparam int OW = 27;

    localparam int K_IDLE  = 0;
    localparam int K_CLEAR = 1;
    localparam int K_FEED  = 2;
    localparam int K_FLUSH = 3;
    localparam int K_DRAIN = 4;
    localparam int K_DONE  = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_s = 1'b0;
    logic abort_s = 1'b0;
    logic ready_s = 1'b0;
    bit   sel4 = 1'b0;

    int checks = 0;
    int errors = 0;

    logic start2, abort2, ready2, start4, abort4, ready4;
    assign start2 = start_s & ~sel4;
    assign abort2 = abort_s & ~sel4;
    assign ready2 = ready_s & ~sel4;
    assign start4 = start_s & sel4;
    assign abort4 = abort_s & sel4;
    assign ready4 = ready_s & sel4;

    logic          sr2, bz2, dn2, pc2, fe2, ce2, dv2;
    logic [CW-1:0] fs2, dr2;
    logic [1:0]    lv2;
    logic [2:0]    st2;
    logic          sr4, bz4, dn4, pc4, fe4, ce4, dv4;
    logic [CW-1:0] fs4, dr4;
    logic [3:0]    lv4;
    logic [2:0]    st4;

    systolic_sequencer #(.MATRIX_SIZE(2), .CNT_W(CW)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .start_ready(sr2),
        .busy(bz2), .done(dn2), .abort(abort2), .pe_clear(pc2),
        .feed_en(fe2), .feed_step(fs2), .lane_valid(lv2), .compute_en(ce2),
        .drain_valid(dv2), .drain_row(dr2), .drain_ready(ready2),
        .state_dbg(st2)
    );

    systolic_sequencer #(.MATRIX_SIZE(4), .CNT_W(CW)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .start_ready(sr4),
        .busy(bz4), .done(dn4), .abort(abort4), .pe_clear(pc4),
        .feed_en(fe4), .feed_step(fs4), .lane_valid(lv4), .compute_en(ce4),
        .drain_valid(dv4), .drain_row(dr4), .drain_ready(ready4),
        .state_dbg(st4)
    );

    // Observation vector of the selected instance.
    logic [OW-1:0] obs;
    assign obs = sel4 ? {bz4, sr4, dn4, pc4, fe4, ce4, dv4, fs4, dr4, lv4}
                      : {bz2, sr2, dn2, pc2, fe2, ce2, dv2, fs2, dr2, 2'b00, lv2};

    // Clock / reset block.
    always #5 clk = ~clk;

    // Expected outputs for one cycle of a given phase, from the run rules.
    function automatic logic [OW-1:0] ev(input int kind, input int idx, input int n);
        logic          bz, sr, dn, pc, fe, ce, dv;
        logic [CW-1:0] fs, dr;
        logic [3:0]    lv;
        bz = (kind != K_IDLE);
        sr = (kind == K_IDLE);
        dn = (kind == K_DONE);
        pc = (kind == K_CLEAR);
        fe = (kind == K_FEED);
        ce = (kind == K_FEED) || (kind == K_FLUSH);
        dv = (kind == K_DRAIN);
        fs = (kind == K_FEED) ? CW'(idx) : '0;
        dr = (kind == K_DRAIN) ? CW'(idx) : '0;
        lv = '0;
        if (kind == K_FEED) begin
            for (int i = 0; i < n; i++) lv[i] = (idx >= i) && (idx - i < n);
        end
        return {bz, sr, dn, pc, fe, ce, dv, fs, dr, lv};
    endfunction

    // Scoreboard check.
    task automatic chk(input string tag, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: apply inputs, clock once, check the resulting cycle.
    task automatic cyc(input logic st, input logic ab, input logic rd,
                       input string tag, input logic [OW-1:0] exp);
        start_s = st;
        abort_s = ab;
        ready_s = rd;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    // One run from IDLE. ab_kind: 0 none, 2 abort in FEED step ab_idx,
    // 3 abort in FLUSH cycle ab_idx, 4 abort in DRAIN row ab_idx.
    task automatic run(input int n, input bit hold, input int stall_row,
                       input int stalls, input int ab_kind, input int ab_idx,
                       input bit rst_drain);
        logic r;
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), "clear", ev(K_CLEAR, 0, n));
        for (int t = 0; t <= 2 * n - 2; t++) begin
            cyc(hold, 1'b0, 1'($urandom_range(0, 1)), "feed", ev(K_FEED, t, n));
            if (ab_kind == K_FEED && ab_idx == t) begin
                cyc(hold, 1'b1, 1'b1, "abort_feed", ev(K_IDLE, 0, n));
                return;
            end
        end
        for (int f = 0; f < n; f++) begin
            cyc(hold, 1'b0, 1'($urandom_range(0, 1)), "flush", ev(K_FLUSH, f, n));
            if (ab_kind == K_FLUSH && ab_idx == f) begin
                cyc(hold, 1'b1, 1'b0, "abort_flush", ev(K_IDLE, 0, n));
                return;
            end
        end
        // The first DRAIN cycle is produced by the last flush edge.
        r = 1'($urandom_range(0, 1));
        start_s = hold;
        ready_s = r;
        @(posedge clk);
        #1;
        chk("drain_enter", ev(K_DRAIN, 0, n));
        if (rst_drain) begin
            #2 reset = 1'b0;
            #1 chk("rst_async", ev(K_IDLE, 0, n));
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        for (int row = 0; row < n; row++) begin
            if (ab_kind == K_DRAIN && ab_idx == row) begin
                cyc(hold, 1'b1, 1'b1, "abort_drain", ev(K_IDLE, 0, n));
                return;
            end
            if (row == stall_row) begin
                for (int s = 0; s < stalls; s++)
                    cyc(hold, 1'b0, 1'b0, "drain_stall", ev(K_DRAIN, row, n));
            end
            if (row < n - 1)
                cyc(hold, 1'b0, 1'b1, "drain_next", ev(K_DRAIN, row + 1, n));
            else
                cyc(hold, 1'b0, 1'b1, "done", ev(K_DONE, 0, n));
        end
        cyc(hold, 1'b0, 1'($urandom_range(0, 1)), "back_idle", ev(K_IDLE, 0, n));
    endtask

    task automatic idle_gap(input int n, input int k);
        for (int i = 0; i < k; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                "idle", ev(K_IDLE, 0, n));
    endtask

    // Directed and randomized sequence.
    initial begin
        #2 reset = 1'b0;
        #1 chk("reset_n2", ev(K_IDLE, 0, 2));
        sel4 = 1'b1;
        #1 chk("reset_n4", ev(K_IDLE, 0, 4));
        sel4 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle_gap(2, 2);

        // N=2 nominal, stalled drain row 1 by 3, abort in FEED at t=1.
        run(2, 1'b0, 0, 0, 0, 0, 1'b0);
        idle_gap(2, 1);
        run(2, 1'b0, 1, 3, 0, 0, 1'b0);
        run(2, 1'b0, 0, 0, K_FEED, 1, 1'b0);
        run(2, 1'b0, 0, 0, 0, 0, 1'b0);

        // start held high: one run per IDLE visit, back to back.
        run(2, 1'b1, 0, 0, 0, 0, 1'b0);
        run(2, 1'b1, 0, 0, 0, 0, 1'b0);
        start_s = 1'b0;
        idle_gap(2, 1);

        // Asynchronous reset in the middle of DRAIN.
        run(2, 1'b0, 0, 0, 0, 0, 1'b1);
        idle_gap(2, 3);
        run(2, 1'b0, 0, 0, 0, 0, 1'b0);

        // Randomized N=2 runs.
        for (int k = 0; k < 20; k++) begin
            int ak;
            ak = $urandom_range(0, 5);
            if (ak > 4) ak = 0;
            if (ak == 1) ak = 0;
            run(2, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                $urandom_range(0, 4), ak, $urandom_range(0, 2), 1'b0);
            start_s = 1'b0;
            idle_gap(2, $urandom_range(0, 2));
        end

        // N=4 instance.
        sel4 = 1'b1;
        idle_gap(4, 1);
        run(4, 1'b0, 0, 0, 0, 0, 1'b0);
        run(4, 1'b0, 2, 2, 0, 0, 1'b0);
        run(4, 1'b0, 0, 0, K_FLUSH, 2, 1'b0);
        run(4, 1'b0, 0, 0, K_DRAIN, 3, 1'b0);
        for (int k = 0; k < 12; k++) begin
            int ak;
            ak = $urandom_range(0, 5);
            if (ak > 4) ak = 0;
            if (ak == 1) ak = 0;
            run(4, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 4), ak, $urandom_range(0, 6), 1'b0);
            start_s = 1'b0;
            idle_gap(4, $urandom_range(0, 2));
        end
        run(4, 1'b0, 0, 0, 0, 0, 1'b1);
        idle_gap(4, 2);

        // Final report.
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
